// File: rtl/console_pkg.sv
// Shared types and widths for the console byte arbiter.
package console_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OUT_W  = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead synchronous FIFO; pointers wrap modulo DEPTH, count carries one extra bit.
module byte_fifo #(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/console_arbiter.sv
// Round-robin merge of two byte producers into one console port, with trap-driven drain.
module console_arbiter
  import console_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0_valid,
  input  logic [BYTE_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [BYTE_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_byte,
  output logic              out_byte_en,
  input  logic              trap,
  output logic              drained,
  output logic [LW-1:0]     fifo_level
);

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [OUT_W-1:0]   out_byte_q, out_byte_d;
  logic               out_byte_en_q, out_byte_en_d;
  logic               drained_q, drained_d;

  logic               fifo_full;
  logic               fifo_empty;
  logic [BYTE_W-1:0]  fifo_dout;
  logic               can_grant;
  logic               gnt0;
  logic               gnt1;
  logic               push;
  logic               pop;
  logic [BYTE_W-1:0]  push_data;

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (push_data),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_level)
  );

  // Grant: the requester not served last time wins a contention.
  always_comb begin
    can_grant = (state_q == ST_RUN) && !fifo_full;
    gnt0      = can_grant & req0_valid & (~req1_valid | last_grant_q);
    gnt1      = can_grant & req1_valid & (~req0_valid | ~last_grant_q);
    push      = gnt0 | gnt1;
    push_data = gnt0 ? req0_data : req1_data;
    pop       = !fifo_empty && out_ready && (state_q != ST_DONE);
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    out_byte_d    = out_byte_q;
    out_byte_en_d = pop;

    if (gnt0) last_grant_d = 1'b0;
    if (gnt1) last_grant_d = 1'b1;
    if (pop)  out_byte_d   = OUT_W'(fifo_dout);

    case (state_q)
      ST_RUN:   if (trap) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !pop) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase

    drained_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_RUN;
      last_grant_q  <= 1'b1;
      out_byte_q    <= '0;
      out_byte_en_q <= 1'b0;
      drained_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      out_byte_q    <= out_byte_d;
      out_byte_en_q <= out_byte_en_d;
      drained_q     <= drained_d;
    end
  end

  assign out_byte    = out_byte_q;
  assign out_byte_en = out_byte_en_q;
  assign drained     = drained_q;

endmodule

// File: doc/console_arbiter.md
# console_arbiter

Shares the system's single console byte port (`out_byte`/`out_byte_en`) between two byte producers: the CPU store path and a hardware debug/status source. Requests are arbitrated round-robin into a shared FIFO, which drains one byte per cycle whenever the sink is ready. On `trap`, intake stops and the FIFO drains. `drained` then tells the bench-level harness it may finish without losing console text.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries. Must be a power of 2 and ≥ 2.
- `LW`, `$clog2(DEPTH)+1`: width of `fifo_level`. Derived; do not override.

Ports:
- `clk` in 1: clock; all logic on posedge.
- `resetn` in 1: reset, synchronous, active-low. Clock `clk`.
- `req0_valid` in 1: CPU byte valid.
- `req0_data` in 8: CPU byte.
- `req0_ready` out 1: CPU byte accepted this cycle when `req0_valid & req0_ready`.
- `req1_valid` in 1: debug byte valid.
- `req1_data` in 8: debug byte.
- `req1_ready` out 1: debug byte accepted this cycle when `req1_valid & req1_ready`.
- `out_ready` in 1: sink can take a byte.
- `out_byte` out 32: emitted byte, zero-extended (bits 31:8 always 0).
- `out_byte_en` out 1: one-cycle strobe per emitted byte.
- `trap` in 1: level; start the drain sequence.
- `drained` out 1: all accepted bytes have been emitted after a trap.
- `fifo_level` out LW: current FIFO occupancy, 0..DEPTH.

## Operation
- States: RUN (reset state), DRAIN, DONE. Encoding lives in the package.
  - RUN → DRAIN when `trap` = 1 is sampled.
  - DRAIN → DONE when the FIFO is empty and no pop occurs this cycle.
  - DONE is held until reset.
- Grant, RUN only and only when FIFO not full:
  - One valid requester: it is granted.
  - Both valid: the requester not granted last time is granted.
  - `last_grant` resets to 1, so `req0` wins the first contention.
- `reqN_ready` = grant to N. It is combinational, depends on `reqN_valid`, and at most one is high per cycle. Requesters must not make `valid` depend on `ready`.
- Full check uses the registered count. No push when full, even if a pop happens in the same cycle.
- A handshake in the cycle `trap` is first sampled is still accepted and later drained.
- Pop: FIFO non-empty & `out_ready` & state ≠ DONE. On pop, the next edge registers `out_byte` = head byte and `out_byte_en` = 1. Otherwise `out_byte_en` = 0 and `out_byte` holds its value.
- Bytes leave strictly in acceptance order. There is no loss and no duplication.
- `drained` = (state == DONE). It is registered.
- `fifo_level` tracks the count: +1 on push, −1 on pop, unchanged on simultaneous push and pop.
- Reset, including mid-operation: FIFO pointers and count go to 0, state goes to RUN, `last_grant` goes to 1. Pending bytes are discarded.

## Timing
- Reset values: `out_byte` = 0, `out_byte_en` = 0, `drained` = 0, `fifo_level` = 0. `req0_ready` and `req1_ready` follow their `valid` inputs combinationally while not full (FIFO is empty out of reset).
- Latency with `out_ready` = 1 and empty FIFO: handshake in cycle N → `out_byte_en` high in cycle N+2.
- Throughput: one accept and one emit per cycle, sustained. `out_byte_en` may stay high on consecutive cycles.
- `out_ready` low stalls popping only. Acceptance continues until full.
- `drained` rises 1 cycle after the cycle in which the last `out_byte_en` is high, when `out_ready` stays 1.

## Structure
- Package `console_pkg`:
  - state enum `{ST_RUN, ST_DRAIN, ST_DONE}`
  - `BYTE_W` = 8
  - `OUT_W` = 32
- Sub-module `byte_fifo`: parameterized synchronous FIFO.
  - Ports: `push`, `pop`, `din`, `dout` (head, show-ahead), `full`, `empty`, `count`.
  - Pointers wrap modulo DEPTH. Count has one extra bit.
- Top level: arbiter, FSM, and output register.

## Test plan
- Single requester: `req0` sends 0x48, 0x69 back-to-back with `out_ready` = 1 → `out_byte_en` high in cycles N+2 and N+3, with `out_byte` = 0x48 then 0x69 (upper bits 0).
- Contention: both requesters held valid with `req0` = 0x41 and `req1` = 0x61 for 4 cycles → grants alternate 0, 1, 0, 1. Output is 0x41, 0x61, 0x41, 0x61.
- Backpressure/full with DEPTH = 8: `out_ready` = 0, `req0` pushes 10 bytes → exactly 8 accepted, `fifo_level` = 8, `req0_ready` = 0. Raising `out_ready` emits the 8 bytes in order, and `fifo_level` returns to 0.
- Trap drain: 5 bytes queued, `trap` pulsed with `req1_valid` high the same cycle → that byte is accepted, no further `reqN_ready`. All 6 bytes are emitted, then `drained` = 1 and stays 1.
- Reset mid-operation: `resetn` = 0 for 1 cycle with 4 bytes queued → next cycle `fifo_level` = 0, `out_byte_en` = 0, state RUN. The next contention grants `req0` first.
- Wrap-around: 3 × DEPTH bytes streamed with `out_ready` toggling every other cycle → output sequence matches input exactly.
